serv_uart_loader: RTL and testbench

UART program loader upstream of the SERV SoC in the fabric user design. It holds the core in reset and receives a framed program image on a serial pin. It writes that image word by word into the servant RAM over a Wishbone-style write port, then releases the core. The top level ORs `core_rst` with the warmboot reset to form the servant `wb_rst`.

---
 rtl/serv_uart_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_serv_uart_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_uart_loader.sv
// UART program loader for the SERV SoC.
// Receives a framed image (A5, len_lo, len_hi, data bytes...) on a UART pin,
// writes it word by word over a Wishbone-style write port, then releases the
// core from reset.
module serv_uart_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int MEM_WORDS    = 1024,
    parameter int AW           = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    output logic          core_rst,
    output logic [AW-1:0] mem_adr,
    output logic [31:0]   mem_dat,
    output logic [3:0]    mem_sel,
    output logic          mem_we,
    output logic          mem_stb,
    input  logic          mem_ack,
    output logic          busy,
    output logic          error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] SYNC   = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] LEN_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic          rx_s1_q, rx_s2_q;
    logic [1:0]    rx_state_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    rx_byte_q;
    logic          byte_valid_q, frame_err_q;

    logic [2:0]    ld_state_q;
    logic [7:0]    len_lo_q;
    logic [15:0]   remain_q;
    logic [1:0]    bcnt_q;
    logic [AW-1:0] adr_q;
    logic [31:0]   dat_q;
    logic          stb_q, core_rst_q, busy_q, error_q;

    logic [15:0]   len_n;
    logic          too_big;

    assign len_n   = {rx_byte_q, len_lo_q};
    assign too_big = {16'd0, len_n} > 32'(MEM_WORDS);

    assign core_rst = core_rst_q;
    assign mem_adr  = adr_q;
    assign mem_dat  = dat_q;
    assign mem_stb  = stb_q;
    assign mem_we   = stb_q;
    assign mem_sel  = stb_q ? 4'hF : 4'h0;
    assign busy     = busy_q;
    assign error    = error_q;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    // 8N1 receiver: mid-bit sampling, glitch reject on start, framing check on stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    if (!rx_s2_q) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt_q == HALF_M1) begin
                        clk_cnt_q  <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_q <= '0;
                        rx_byte_q <= {rx_s2_q, rx_byte_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_q  <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rx_s2_q) byte_valid_q <= 1'b1;
                        else         frame_err_q  <= 1'b1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Loader FSM: sync, length, assemble words, issue writes, release core.
    // An ack in WRITE wins over a byte arriving the same cycle; that byte is
    // kept as the first byte of the next word instead of being an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_state_q <= SYNC;
            len_lo_q   <= '0;
            remain_q   <= '0;
            bcnt_q     <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            stb_q      <= 1'b0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (ld_state_q)
                SYNC, DONE: begin
                    if (byte_valid_q && rx_byte_q == 8'hA5) begin
                        core_rst_q <= 1'b1;
                        busy_q     <= 1'b1;
                        error_q    <= 1'b0;
                        adr_q      <= '0;
                        ld_state_q <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (byte_valid_q) begin
                        len_lo_q   <= rx_byte_q;
                        ld_state_q <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (byte_valid_q) begin
                        remain_q <= len_n;
                        bcnt_q   <= '0;
                        if (len_n == 16'd0) begin
                            core_rst_q <= 1'b0;
                            busy_q     <= 1'b0;
                            ld_state_q <= DONE;
                        end else if (too_big) begin
                            error_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            ld_state_q <= SYNC;
                        end else begin
                            ld_state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (byte_valid_q) begin
                        dat_q  <= {rx_byte_q, dat_q[31:8]};
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            stb_q      <= 1'b1;
                            ld_state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        stb_q    <= 1'b0;
                        adr_q    <= adr_q + AW'(4);
                        remain_q <= remain_q - 16'd1;
                        if (remain_q == 16'd1) begin
                            core_rst_q <= 1'b0;
                            busy_q     <= 1'b0;
                            ld_state_q <= DONE;
                        end else begin
                            ld_state_q <= DATA;
                            if (byte_valid_q) begin
                                dat_q  <= {rx_byte_q, dat_q[31:8]};
                                bcnt_q <= 2'd1;
                            end
                        end
                    end else if (byte_valid_q) begin
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        stb_q      <= 1'b0;
                        ld_state_q <= SYNC;
                    end
                end
                default: ld_state_q <= SYNC;
            endcase
            if (frame_err_q) begin
                error_q    <= 1'b1;
                busy_q     <= 1'b0;
                stb_q      <= 1'b0;
                ld_state_q <= SYNC;
            end
        end
    end

endmodule

// File: tb/tb_serv_uart_loader.sv
// Scoreboard bench for serv_uart_loader: expected writes are queued by the
// stimulus, and a monitor pops and compares on every write handshake.
module tb_serv_uart_loader;

    localparam int CPB = 16;
    localparam int AW  = 12;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [31:0]   dat;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset, rx, mem_ack;
    logic          core_rst, mem_we, mem_stb, busy, error;
    logic [AW-1:0] mem_adr;
    logic [31:0]   mem_dat;
    logic [3:0]    mem_sel;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  ack_dly  = 0;
    bit  ack_block = 1'b0;

    serv_uart_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(1024), .AW(AW)) dut (
        .clk(clk), .reset(reset), .rx(rx), .core_rst(core_rst),
        .mem_adr(mem_adr), .mem_dat(mem_dat), .mem_sel(mem_sel),
        .mem_we(mem_we), .mem_stb(mem_stb), .mem_ack(mem_ack),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
        rx = stop;
        wait_cyc(CPB);
        rx = 1'b1;
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.adr = a;
        e.dat = d;
        exp_q.push_back(e);
    endtask

    // Ack driver and write monitor. An ack raised here is taken at the next
    // posedge, so the write is scored at the moment ack is raised.
    initial begin
        int            wcnt;
        bit            in_txn;
        logic [AW-1:0] h_adr;
        logic [31:0]   h_dat;
        wr_t           e;
        wcnt    = 0;
        in_txn  = 1'b0;
        h_adr   = '0;
        h_dat   = '0;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || !mem_stb) begin
                mem_ack = 1'b0;
                wcnt    = 0;
                in_txn  = 1'b0;
            end else begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    h_adr  = mem_adr;
                    h_dat  = mem_dat;
                end else begin
                    chk("stable_adr", 32'(mem_adr), 32'(h_adr));
                    chk("stable_dat", mem_dat, h_dat);
                end
                if (!ack_block) begin
                    if (wcnt >= ack_dly) mem_ack = 1'b1;
                    else wcnt++;
                end
                if (mem_ack) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: adr %h dat %h", mem_adr, mem_dat);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_adr", 32'(mem_adr), 32'(e.adr));
                        chk("wr_dat", mem_dat, e.dat);
                        chk("wr_sel", 32'(mem_sel), 32'hF);
                        chk("wr_we", 32'(mem_we), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v[$];
        reset = 1'b1;
        rx    = 1'b1;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(2);
        chk("rst_core_rst", 32'(core_rst), 1);
        chk("rst_stb", 32'(mem_stb), 0);
        chk("rst_sel", 32'(mem_sel), 0);
        chk("rst_adr", 32'(mem_adr), 0);
        chk("rst_dat", mem_dat, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_error", 32'(error), 0);

        // Nominal two-word load with a 3-cycle glitch inserted mid-word.
        push(12'h000, 32'h12345678);
        push(12'h004, 32'hDEADBEEF);
        v = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56};
        send_q(v);
        chk("load_busy", 32'(busy), 1);
        rx = 1'b0;
        wait_cyc(3);
        rx = 1'b1;
        wait_cyc(40);
        chk("glitch_error", 32'(error), 0);
        v = '{8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_q(v);
        wait_cyc(20);
        chk("nom_core_rst", 32'(core_rst), 0);
        chk("nom_busy", 32'(busy), 0);
        chk("nom_error", 32'(error), 0);

        // Reload after DONE with 5 wait states on the ack.
        ack_dly = 5;
        v = '{8'hA5};
        send_q(v);
        wait_cyc(10);
        chk("reload_core_rst", 32'(core_rst), 1);
        chk("reload_busy", 32'(busy), 1);
        chk("reload_adr", 32'(mem_adr), 0);
        push(12'h000, 32'h44332211);
        v = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_q(v);
        wait_cyc(30);
        chk("reload_done", 32'(core_rst), 0);
        ack_dly = 0;

        // Framing error, recovery by sync, then oversize length.
        v = '{8'hA5};
        send_q(v);
        send_byte(8'h01, 1'b0);
        wait_cyc(40);
        chk("frm_error", 32'(error), 1);
        chk("frm_busy", 32'(busy), 0);
        chk("frm_core_rst", 32'(core_rst), 1);
        chk("frm_stb", 32'(mem_stb), 0);
        v = '{8'hA5};
        send_q(v);
        wait_cyc(10);
        chk("sync_clr_error", 32'(error), 0);
        chk("sync_busy", 32'(busy), 1);
        v = '{8'h01, 8'h04};
        send_q(v);
        wait_cyc(20);
        chk("big_error", 32'(error), 1);
        chk("big_busy", 32'(busy), 0);
        chk("big_core_rst", 32'(core_rst), 1);

        // Empty image releases the core straight after the length.
        v = '{8'hA5, 8'h00};
        send_q(v);
        chk("empty_pre_core_rst", 32'(core_rst), 1);
        v = '{8'h00};
        send_q(v);
        wait_cyc(2);
        chk("empty_core_rst", 32'(core_rst), 0);
        chk("empty_busy", 32'(busy), 0);
        chk("empty_error", 32'(error), 0);

        // Overrun: ack withheld until the next byte arrives.
        ack_block = 1'b1;
        v = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_q(v);
        wait_cyc(20);
        chk("ovr_stb_up", 32'(mem_stb), 1);
        chk("ovr_sel", 32'(mem_sel), 32'hF);
        chk("ovr_adr", 32'(mem_adr), 0);
        chk("ovr_dat", mem_dat, 32'h04030201);
        v = '{8'h05};
        send_q(v);
        wait_cyc(10);
        chk("ovr_error", 32'(error), 1);
        chk("ovr_stb_down", 32'(mem_stb), 0);
        chk("ovr_busy", 32'(busy), 0);
        ack_block = 1'b0;

        // Reset asserted mid-DATA clears outputs without a clock edge.
        v = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
        send_q(v);
        wait_cyc(5);
        reset = 1'b1;
        #1;
        chk("arst_core_rst", 32'(core_rst), 1);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_dat", mem_dat, 0);
        chk("arst_adr", 32'(mem_adr), 0);
        chk("arst_stb", 32'(mem_stb), 0);
        chk("arst_error", 32'(error), 0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);

        // Clean load after reset.
        push(12'h000, 32'hCAFEF00D);
        v = '{8'hA5, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        send_q(v);
        wait_cyc(20);
        chk("final_core_rst", 32'(core_rst), 0);
        chk("final_busy", 32'(busy), 0);
        chk("final_error", 32'(error), 0);
        chk("writes_left", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
